// File: rtl/mem_wb_if.sv
// MEM->WB stage bus: incoming MEM-stage instruction, pipeline control, and register-bank write port.
// Optional WB_BYPASS_EN adds the forwarding lookup ports.
interface mem_wb_if #(
  parameter int unsigned CNT_W = 16
);

  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [4:0]        in_wreg;
  logic [31:0]       in_alu;
  logic [31:0]       in_memdata;
  logic [2:0]        in_loadop;
  logic [1:0]        in_addr_lo;

  logic [4:0]        WriteRegister;
  logic [31:0]       WriteData;
  logic              RegWrite;
  logic              out_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  retired;

`ifdef WB_BYPASS_EN
  logic [4:0]        fwd_ar1;
  logic [4:0]        fwd_ar2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [31:0]       fwd_dr1;
  logic [31:0]       fwd_dr2;

  modport master (
    output stall, flush, in_valid, in_regwrite, in_memtoreg, in_wreg,
           in_alu, in_memdata, in_loadop, in_addr_lo, fwd_ar1, fwd_ar2,
    input  WriteRegister, WriteData, RegWrite, out_valid, misalign_err,
           retired, fwd_hit1, fwd_hit2, fwd_dr1, fwd_dr2
  );

  modport slave (
    input  stall, flush, in_valid, in_regwrite, in_memtoreg, in_wreg,
           in_alu, in_memdata, in_loadop, in_addr_lo, fwd_ar1, fwd_ar2,
    output WriteRegister, WriteData, RegWrite, out_valid, misalign_err,
           retired, fwd_hit1, fwd_hit2, fwd_dr1, fwd_dr2
  );
`else
  modport master (
    output stall, flush, in_valid, in_regwrite, in_memtoreg, in_wreg,
           in_alu, in_memdata, in_loadop, in_addr_lo,
    input  WriteRegister, WriteData, RegWrite, out_valid, misalign_err,
           retired
  );

  modport slave (
    input  stall, flush, in_valid, in_regwrite, in_memtoreg, in_wreg,
           in_alu, in_memdata, in_loadop, in_addr_lo,
    output WriteRegister, WriteData, RegWrite, out_valid, misalign_err,
           retired
  );
`endif

endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: load extraction/extension, misaligned-load detection, retire counter.
// Define WB_BYPASS_EN to add the combinational write-back forwarding lookup.
module mem_wb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_wb_if.slave  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } loadop_e;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  result;
  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             misaligned;
  logic             wr_en;

  logic             valid_q;
  logic             regwrite_q;
  logic [REG_W-1:0] wreg_q;
  logic [XLEN-1:0]  wdata_q;
  logic             err_q;
  logic [CNT_W-1:0] retired_q;

  // Little-endian lane selection and width/sign extension of the loaded word
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = bus.in_memdata;
    is_byte   = 1'b0;
    is_half   = 1'b0;

    case (bus.in_addr_lo)
      2'd0:    byte_sel = bus.in_memdata[7:0];
      2'd1:    byte_sel = bus.in_memdata[15:8];
      2'd2:    byte_sel = bus.in_memdata[23:16];
      default: byte_sel = bus.in_memdata[31:24];
    endcase
    half_sel = bus.in_addr_lo[1] ? bus.in_memdata[31:16] : bus.in_memdata[15:0];

    case (bus.in_loadop)
      LD_B: begin
        is_byte   = 1'b1;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      LD_BU: begin
        is_byte   = 1'b1;
        load_data = {24'h000000, byte_sel};
      end
      LD_H: begin
        is_half   = 1'b1;
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      LD_HU: begin
        is_half   = 1'b1;
        load_data = {16'h0000, half_sel};
      end
      default: load_data = bus.in_memdata;
    endcase

    is_word = !is_byte && !is_half;
    result  = bus.in_memtoreg ? load_data : bus.in_alu;
  end

  // Misalignment only matters for a real load; it kills the write but not the instruction
  always_comb begin
    misaligned = bus.in_valid && bus.in_memtoreg &&
                 ((is_half && bus.in_addr_lo[0]) ||
                  (is_word && (bus.in_addr_lo != 2'd0)));
    wr_en      = bus.in_valid && bus.in_regwrite && !misaligned &&
                 (bus.in_wreg != REG_W'(0));
  end

  // Stage register: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      retired_q  <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else if (!bus.stall) begin
      valid_q    <= bus.in_valid;
      regwrite_q <= wr_en;
      wreg_q     <= bus.in_wreg;
      wdata_q    <= result;
      if (misaligned) begin
        err_q <= 1'b1;
      end
      if (bus.in_valid) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.RegWrite      = regwrite_q;
  assign bus.WriteRegister = wreg_q;
  assign bus.WriteData     = wdata_q;
  assign bus.misalign_err  = err_q;
  assign bus.retired       = retired_q;

`ifdef WB_BYPASS_EN
  // Forward the value being written back to a same-cycle register read
  always_comb begin
    bus.fwd_hit1 = regwrite_q && (wreg_q == bus.fwd_ar1);
    bus.fwd_hit2 = regwrite_q && (wreg_q == bus.fwd_ar2);
    bus.fwd_dr1  = bus.fwd_hit1 ? wdata_q : '0;
    bus.fwd_dr2  = bus.fwd_hit2 ? wdata_q : '0;
  end
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Testbench for mem_wb: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_mem_wb;

  localparam int unsigned CNTW = 4;

  logic clk = 1'b0;
  logic rst_n;

  mem_wb_if #(.CNT_W(CNTW)) bus();

  mem_wb #(.CNT_W(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference state
  bit           m_valid = 1'b0;
  bit           m_rw = 1'b0;
  int unsigned  m_wreg = 0;
  logic [31:0]  m_wdata = 32'h0;
  bit           m_err = 1'b0;
  int unsigned  m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_result(input bit m2r, input logic [31:0] alu,
                                               input logic [31:0] md, input int unsigned op,
                                               input int unsigned lo);
    longint v;
    longint unsigned w;
    w = longint'(md);
    if (!m2r) return alu;
    case (op)
      1: begin v = longint'((w >> (8 * lo)) % 256); if (v > 127) v = v - 256; end
      2: v = longint'((w >> (8 * lo)) % 256);
      3: begin v = longint'((w >> (16 * (lo / 2))) % 65536); if (v > 32767) v = v - 65536; end
      4: v = longint'((w >> (16 * (lo / 2))) % 65536);
      default: v = longint'(w);
    endcase
    return 32'(v);
  endfunction

  function automatic bit model_misaligned(input bit vld, input bit m2r, input int unsigned op,
                                          input int unsigned lo);
    if (!vld || !m2r) return 1'b0;
    if (op == 3 || op == 4) return (lo % 2) != 0;
    if (op == 1 || op == 2) return 1'b0;
    return lo != 0;
  endfunction

  // Model advance on every clock edge from the inputs presented to it
  always @(posedge clk) begin
    bit mis;
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_wreg = 0; m_wdata = 0; m_err = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_rw = 0; m_wreg = 0; m_wdata = 0;
    end else if (!bus.stall) begin
      mis     = model_misaligned(bus.in_valid, bus.in_memtoreg, bus.in_loadop, bus.in_addr_lo);
      m_valid = bus.in_valid;
      m_wreg  = bus.in_wreg;
      m_wdata = model_result(bus.in_memtoreg, bus.in_alu, bus.in_memdata,
                             bus.in_loadop, bus.in_addr_lo);
      m_rw    = bus.in_valid && bus.in_regwrite && !mis && (m_wreg != 0);
      if (mis) m_err = 1'b1;
      if (bus.in_valid) m_cnt = (m_cnt + 1) % (1 << CNTW);
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("cmp_RegWrite", 32'(bus.RegWrite), 32'(m_rw));
      chk("cmp_WriteRegister", 32'(bus.WriteRegister), 32'(m_wreg));
      chk("cmp_WriteData", bus.WriteData, m_wdata);
      chk("cmp_misalign_err", 32'(bus.misalign_err), 32'(m_err));
      chk("cmp_retired", 32'(bus.retired), 32'(m_cnt));
`ifdef WB_BYPASS_EN
      chk("cmp_fwd_hit1", 32'(bus.fwd_hit1), 32'(m_rw && (m_wreg == bus.fwd_ar1)));
      chk("cmp_fwd_hit2", 32'(bus.fwd_hit2), 32'(m_rw && (m_wreg == bus.fwd_ar2)));
      chk("cmp_fwd_dr1", bus.fwd_dr1, (m_rw && (m_wreg == bus.fwd_ar1)) ? m_wdata : 32'h0);
      chk("cmp_fwd_dr2", bus.fwd_dr2, (m_rw && (m_wreg == bus.fwd_ar2)) ? m_wdata : 32'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] wreg,
                       input logic [31:0] alu, input logic [31:0] md,
                       input logic [2:0] op, input logic [1:0] lo);
    bus.in_valid    = v;
    bus.in_regwrite = rw;
    bus.in_memtoreg = m2r;
    bus.in_wreg     = wreg;
    bus.in_alu      = alu;
    bus.in_memdata  = md;
    bus.in_loadop   = op;
    bus.in_addr_lo  = lo;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] md;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads[5];

  initial begin
    loads[0] = '{3'b100, 2'd2, 32'h8001ABCD, 32'h00008001};
    loads[1] = '{3'b011, 2'd2, 32'h8001ABCD, 32'hFFFF8001};
    loads[2] = '{3'b010, 2'd0, 32'h80FF7F01, 32'h00000001};
    loads[3] = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    loads[4] = '{3'b011, 2'd0, 32'h8001ABCD, 32'hFFFFABCD};

    rst_n     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
`ifdef WB_BYPASS_EN
    bus.fwd_ar1 = 5'd0;
    bus.fwd_ar2 = 5'd0;
`endif
    drive(1, 1, 1, 5'd3, 32'h11111111, 32'h22222222, 3'b000, 2'd0);
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_WriteData", bus.WriteData, 32'h0);
    chk("rst_retired", 32'(bus.retired), 32'd0);

    // Valid lb from byte 2, first capture right after reset release
    rst_n = 1'b1;
    drive(1, 1, 1, 5'd5, 32'h0, 32'h80FF7F01, 3'b001, 2'd2);
    tick();
    chk("lb_WriteData", bus.WriteData, 32'hFFFFFFFF);
    chk("lb_RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("lb_WriteRegister", 32'(bus.WriteRegister), 32'd5);
    chk("lb_retired", 32'(bus.retired), 32'd1);

    foreach (loads[i]) begin
      drive(1, 1, 1, 5'd6, 32'h0, loads[i].md, loads[i].op, loads[i].lo);
      tick();
      chk($sformatf("load%0d_WriteData", i), bus.WriteData, loads[i].exp);
    end
    chk("loads_retired", 32'(bus.retired), 32'd6);

    // ALU result to r0: loadop ignored, no write
    drive(1, 1, 0, 5'd0, 32'h12345678, 32'hDEADBEEF, 3'b001, 2'd1);
    tick();
    chk("alu_WriteData", bus.WriteData, 32'h12345678);
    chk("alu_RegWrite", 32'(bus.RegWrite), 32'd0);

    // Flush beats stall
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    drive(1, 1, 0, 5'd9, 32'h55AA55AA, 32'h0, 3'b000, 2'd0);
    tick();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_WriteData", bus.WriteData, 32'h0);
    chk("flush_retired", 32'(bus.retired), 32'd7);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Misaligned lw: write suppressed, flag sticky
    drive(1, 1, 1, 5'd8, 32'h0, 32'hCAFEBABE, 3'b000, 2'd1);
    tick();
    chk("mis_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("mis_out_valid", 32'(bus.out_valid), 32'd1);
    chk("mis_err", 32'(bus.misalign_err), 32'd1);
    drive(1, 1, 1, 5'd8, 32'h0, 32'hCAFEBABE, 3'b011, 2'd1);
    tick();
    drive(1, 1, 1, 5'd7, 32'h0, 32'hCAFEBABE, 3'b000, 2'd0);
    tick();
    chk("aligned_RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("sticky_err", 32'(bus.misalign_err), 32'd1);

    // Invalid slot: no write, no retire
    drive(0, 1, 0, 5'd4, 32'h0BADF00D, 32'h0, 3'b000, 2'd0);
    tick();
    chk("inv_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("inv_retired", 32'(bus.retired), 32'd10);

    // Reset during stall clears everything including the sticky flag
    bus.stall = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rststall_err", 32'(bus.misalign_err), 32'd0);
    chk("rststall_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    bus.stall = 1'b0;

    // Wrap: 16 valid captures on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 5'(i + 1), 32'(i * 32'h01010101), 32'h0, 3'b000, 2'd0);
      tick();
      if (i == 14) chk("cnt15_retired", 32'(bus.retired), 32'd15);
    end
    chk("wrap_retired", 32'(bus.retired), 32'd0);
    chk("wrap_WriteData", bus.WriteData, 32'h0F0F0F0F);

    // Stall three cycles while inputs change
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 5'd2, 32'h0, 32'h13572468, 3'b001, 2'(i));
      tick();
      chk("stall_WriteData", bus.WriteData, 32'h0F0F0F0F);
      chk("stall_retired", 32'(bus.retired), 32'd0);
    end
    bus.stall = 1'b0;

`ifdef WB_BYPASS_EN
    drive(1, 1, 0, 5'd9, 32'hCAFEF00D, 32'h0, 3'b000, 2'd0);
    bus.fwd_ar1 = 5'd9;
    bus.fwd_ar2 = 5'd0;
    tick();
    chk("byp_hit1", 32'(bus.fwd_hit1), 32'd1);
    chk("byp_dr1", bus.fwd_dr1, 32'hCAFEF00D);
    chk("byp_hit2", 32'(bus.fwd_hit2), 32'd0);
    chk("byp_dr2", bus.fwd_dr2, 32'h0);
`endif

    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
